// File: rtl/tpu_result_drain.sv
// Reads one diagonal-packed 8x8 result matrix from a selected result SRAM bank,
// de-skews it into a row buffer, and streams the rows out over valid/ready.
module tpu_result_drain #(
  parameter int ARRAY_SIZE     = 8,
  parameter int OUT_DATA_WIDTH = 16,
  parameter int ADDR_WIDTH     = 6
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [1:0]                           sel,
  input  logic [ARRAY_SIZE*OUT_DATA_WIDTH-1:0] sram_rdata_c0,
  input  logic [ARRAY_SIZE*OUT_DATA_WIDTH-1:0] sram_rdata_c1,
  input  logic [ARRAY_SIZE*OUT_DATA_WIDTH-1:0] sram_rdata_c2,
  output logic [ADDR_WIDTH-1:0]                sram_raddr_c,
  output logic [ARRAY_SIZE*OUT_DATA_WIDTH-1:0] row_data,
  output logic [2:0]                           row_idx,
  output logic                                 row_valid,
  input  logic                                 row_ready,
  output logic                                 busy,
  output logic                                 done
);

  localparam int ROW_W = ARRAY_SIZE * OUT_DATA_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_EMIT, S_DONE} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  row_q, row_d;
  logic [1:0]  sel_q, sel_d;

  logic [ROW_W-1:0] buf_q [ARRAY_SIZE];
  logic [ROW_W-1:0] word;
  logic [3:0]       diag_k;
  logic             cap_en;
  logic [2:0]       lane_i  [ARRAY_SIZE];
  logic [2:0]       lane_j  [ARRAY_SIZE];
  logic             lane_ok [ARRAY_SIZE];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours, independent of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      row_q   <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      sel_q   <= sel_d;
    end
  end

  // NOTE: every signal gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    sel_d   = sel_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          sel_d   = sel;
          cnt_d   = '0;
          row_d   = '0;
          state_d = S_READ;
        end
      end
      S_READ: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          row_d   = '0;
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        if (row_ready) begin
          row_d = row_q + 3'd1;
          if (row_q == 3'd7) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    unique case (sel_q)
      2'd0:    word = sram_rdata_c0;
      2'd1:    word = sram_rdata_c1;
      2'd2:    word = sram_rdata_c2;
      default: word = '0;
    endcase
  end

  // Read data lags the address by one cycle, so counter value c carries diagonal c-1.
  assign diag_k = cnt_q - 4'd1;
  assign cap_en = (state_q == S_READ) && (cnt_q != 4'd0);

  // Lower half of the diagonals is packed by column (lane 7-j), upper half by row (lane i).
  always_comb begin
    lane_i  = '{default: '0};
    lane_j  = '{default: '0};
    lane_ok = '{default: 1'b0};
    for (int l = 0; l < ARRAY_SIZE; l++) begin
      if (diag_k <= 4'd7) begin
        lane_j[l]  = 3'(ARRAY_SIZE - 1 - l);
        lane_i[l]  = 3'(int'(diag_k) + l - (ARRAY_SIZE - 1));
        lane_ok[l] = (int'(diag_k) + l) >= (ARRAY_SIZE - 1);
      end else begin
        lane_i[l]  = 3'(l);
        lane_j[l]  = 3'(int'(diag_k) - l);
        lane_ok[l] = l >= (int'(diag_k) - (ARRAY_SIZE - 1));
      end
    end
  end

  // NOTE: the matrix buffer has no reset; every element is rewritten before it is emitted.
  always_ff @(posedge clk) begin
    if (cap_en) begin
      for (int l = 0; l < ARRAY_SIZE; l++) begin
        if (lane_ok[l]) begin
          buf_q[lane_i[l]][int'(lane_j[l])*OUT_DATA_WIDTH +: OUT_DATA_WIDTH]
            <= word[l*OUT_DATA_WIDTH +: OUT_DATA_WIDTH];
        end
      end
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);
  assign row_valid    = (state_q == S_EMIT);
  assign row_idx      = row_valid ? row_q : 3'd0;
  assign row_data     = row_valid ? buf_q[row_q] : '0;
  assign sram_raddr_c = (state_q == S_READ)
                      ? ADDR_WIDTH'((cnt_q > 4'd14) ? 4'd14 : cnt_q)
                      : '0;

endmodule
